wb_commit_stage: RTL and testbench

- Final writeback/commit stage of the single-issue RV64 NPC pipeline; accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Writes the 64-bit GPR file and serves decode read ports with write-through bypass.
- Presents a registered, one-record-per-cycle commit stream (commit_valid, commit_pc, commit_inst, is_break) and a flattened register snapshot to the downstream simulation/difftest DPI model.
- Detects ebreak, halts retirement, counts retired instructions and flags a commit-stall watchdog timeout.

---
 rtl/npc_pkg.sv | 18 +
 rtl/wb_commit_stage_if.sv | 22 ++
 rtl/gpr_file.sv | 41 ++++
 rtl/wb_commit_stage.sv | 98 +++++++++
 tb/tb_wb_commit_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC writeback/commit stage.
package npc_pkg;
   localparam int unsigned XLEN        = 64;
   localparam int unsigned NUM_GPR     = 32;
   localparam int unsigned REG_AW      = 5;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } commit_state_t;

   // Record presented on the commit stream for one retired instruction
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } commit_rec_t;
endpackage

// File: rtl/wb_commit_stage_if.sv
// Retirement handshake from the MEM stage into the commit stage.
interface wb_commit_stage_if
   import npc_pkg::*;
();
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc;
   logic [31:0]       in_inst;
   logic              in_rd_wen;
   logic [REG_AW-1:0] in_rd_addr;
   logic [XLEN-1:0]   in_rd_data;

   modport master (
      output in_valid, in_pc, in_inst, in_rd_wen, in_rd_addr, in_rd_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_pc, in_inst, in_rd_wen, in_rd_addr, in_rd_data,
      output in_ready
   );
endinterface

// File: rtl/gpr_file.sv
// 32 x XLEN GPR file: one write port, two bypassed read ports, flat snapshot.
module gpr_file
   import npc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wen,
   input  logic [REG_AW-1:0]         waddr,
   input  logic [XLEN-1:0]           wdata,
   input  logic [REG_AW-1:0]         rs1_addr,
   input  logic [REG_AW-1:0]         rs2_addr,
   output logic [XLEN-1:0]           rs1_data,
   output logic [XLEN-1:0]           rs2_data,
   output logic [NUM_GPR*XLEN-1:0]   rf_flat
);
   logic [XLEN-1:0] regs [NUM_GPR];
   logic            wr_live;
   logic            byp1;
   logic            byp2;

   assign wr_live = wen && (waddr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_GPR; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[waddr] <= wdata;
      end
   end

   // Same-cycle bypass lets decode see a value retiring this cycle
   assign byp1     = wr_live && (rs1_addr == waddr);
   assign byp2     = wr_live && (rs2_addr == waddr);
   assign rs1_data = (rs1_addr == '0) ? '0 : (byp1 ? wdata : regs[rs1_addr]);
   assign rs2_data = (rs2_addr == '0) ? '0 : (byp2 ? wdata : regs[rs2_addr]);

   always_comb begin
      rf_flat = '0;
      for (int i = 1; i < NUM_GPR; i++) rf_flat[i*XLEN +: XLEN] = regs[i];
   end
endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: GPR writes, registered commit stream, ebreak halt,
// retired-instruction count and commit-stall watchdog.
module wb_commit_stage
   import npc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   wb_commit_stage_if.slave        bus,
   input  logic [REG_AW-1:0]       rs1_addr,
   input  logic [REG_AW-1:0]       rs2_addr,
   output logic [XLEN-1:0]         rs1_data,
   output logic [XLEN-1:0]         rs2_data,
   output logic                    commit_valid,
   output logic [XLEN-1:0]         commit_pc,
   output logic [31:0]             commit_inst,
   output logic                    is_break,
   output logic [NUM_GPR*XLEN-1:0] rf_flat,
   output logic [63:0]             instret,
   output logic                    timeout
);
   localparam int unsigned      CNT_W       = 16;
   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

   commit_state_t    state_q;
   commit_state_t    state_d;
   commit_rec_t      commit_q;
   logic             fire;
   logic             is_ebreak;
   logic [CNT_W-1:0] stall_cnt;

   assign bus.in_ready = (state_q == RUN);
   assign fire         = bus.in_valid && (state_q == RUN);
   assign is_ebreak    = (bus.in_inst == EBREAK_INST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (fire && is_ebreak) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // Commit stream, ebreak flag and retired count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_valid <= 1'b0;
         commit_q     <= '0;
         is_break     <= 1'b0;
         instret      <= '0;
      end else begin
         commit_valid <= fire;
         if (fire) begin
            commit_q <= '{pc: bus.in_pc, inst: bus.in_inst};
            instret  <= instret + 64'd1;
            if (is_ebreak) is_break <= 1'b1;
         end
      end
   end

   assign commit_pc   = commit_q.pc;
   assign commit_inst = commit_q.inst;

   // Watchdog: saturating stall count, frozen once halted; a fire always wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else if (state_q == RUN) begin
         if (fire) begin
            stall_cnt <= '0;
         end else begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (stall_cnt >= STALL_LIMIT) timeout <= 1'b1;
         end
      end
   end

   gpr_file u_gpr (
      .clk      (clk),
      .rst      (rst),
      .wen      (fire && bus.in_rd_wen),
      .waddr    (bus.in_rd_addr),
      .wdata    (bus.in_rd_data),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rf_flat  (rf_flat)
   );
endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed self-checking bench for wb_commit_stage.
module tb_wb_commit_stage;
   import npc_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [REG_AW-1:0]       rs1_addr = '0;
   logic [REG_AW-1:0]       rs2_addr = '0;
   logic [XLEN-1:0]         rs1_data, rs2_data;
   logic                    commit_valid;
   logic [XLEN-1:0]         commit_pc;
   logic [31:0]             commit_inst;
   logic                    is_break;
   logic [NUM_GPR*XLEN-1:0] rf_flat;
   logic [63:0]             instret;
   logic                    timeout;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] exp_rf [NUM_GPR];

   wb_commit_stage_if bus ();

   wb_commit_stage #(.TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .is_break     (is_break),
      .rf_flat      (rf_flat),
      .instret      (instret),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] gpr(input int i);
      return rf_flat[i*XLEN +: XLEN];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                        input logic wen, input logic [4:0] rd, input logic [63:0] data);
      bus.in_valid   = v;
      bus.in_pc      = pc;
      bus.in_inst    = inst;
      bus.in_rd_wen  = wen;
      bus.in_rd_addr = rd;
      bus.in_rd_data = data;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int i = 0; i < NUM_GPR; i++) exp_rf[i] = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int cv_cycles;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_commit_pc",    commit_pc, 64'd0);
      check("rst_instret",      instret, 64'd0);
      check("rst_is_break",     64'(is_break), 64'd0);
      check("rst_timeout",      64'(timeout), 64'd0);
      check("rst_in_ready",     64'(bus.in_ready), 64'd1);
      rst = 1'b0;

      // First commit, 1-cycle latency
      drive(1'b1, 64'h8000_0000, 32'h0000_0093, 1'b1, 5'd1, 64'h5);
      step();
      check("t1_commit_valid", 64'(commit_valid), 64'd1);
      check("t1_commit_pc",    commit_pc, 64'h8000_0000);
      check("t1_commit_inst",  64'(commit_inst), 64'h93);
      check("t1_x1",           gpr(1), 64'h5);
      check("t1_instret",      instret, 64'd1);

      // x0 write dropped, no bypass on x0
      drive(1'b1, 64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'hDEAD);
      rs1_addr = 5'd0;
      #1;
      check("x0_rs1_bypass", rs1_data, 64'd0);
      step();
      check("x0_rf_flat",  gpr(0), 64'd0);
      check("x0_rs1_data", rs1_data, 64'd0);
      check("t2_pc",       commit_pc, 64'h8000_0004);

      // Same-cycle bypass on rs2
      drive(1'b1, 64'h8000_0008, 32'h0000_0013, 1'b1, 5'd3, 64'h77);
      rs2_addr = 5'd3;
      #1;
      check("rs2_bypass", rs2_data, 64'h77);
      step();
      check("x3_written", gpr(3), 64'h77);

      // No bypass and no write without valid
      drive(1'b0, 64'h8000_000C, 32'h0000_0013, 1'b1, 5'd4, 64'h99);
      rs1_addr = 5'd4;
      #1;
      check("nofire_rs1_nobypass", rs1_data, 64'd0);
      step();
      check("nofire_commit_valid", 64'(commit_valid), 64'd0);
      check("nofire_pc_hold",      commit_pc, 64'h8000_0008);
      check("nofire_instret",      instret, 64'd3);
      check("nofire_x4",           gpr(4), 64'd0);

      // 100 back-to-back fires, rd cycling 1..31
      do_reset();
      cv_cycles = 0;
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, 64'h8000_1000 + 64'(4*k), 32'h0000_0013, 1'b1,
               5'((k % 31) + 1), 64'h1000 + 64'(k));
         exp_rf[(k % 31) + 1] = 64'h1000 + 64'(k);
         step();
         if (commit_valid === 1'b1) cv_cycles++;
      end
      check("b2b_valid_cycles", 64'(cv_cycles), 64'd100);
      check("b2b_instret",      instret, 64'd100);
      check("b2b_last_pc",      commit_pc, 64'h8000_1000 + 64'(4*99));
      check("b2b_timeout",      64'(timeout), 64'd0);
      for (int r = 1; r < NUM_GPR; r++) check($sformatf("b2b_x%0d", r), gpr(r), exp_rf[r]);

      // ebreak commits then halts
      drive(1'b1, 64'h8000_0010, EBREAK_INST, 1'b0, 5'd0, 64'd0);
      step();
      check("brk_is_break",     64'(is_break), 64'd1);
      check("brk_commit_valid", 64'(commit_valid), 64'd1);
      check("brk_commit_pc",    commit_pc, 64'h8000_0010);
      check("brk_in_ready",     64'(bus.in_ready), 64'd0);
      check("brk_instret",      instret, 64'd101);

      drive(1'b1, 64'h8000_0014, 32'h0000_0013, 1'b1, 5'd5, 64'hBAD);
      rs1_addr = 5'd5;
      #1;
      check("halt_no_bypass", rs1_data, exp_rf[5]);
      repeat (10) step();
      check("halt_commit_valid", 64'(commit_valid), 64'd0);
      check("halt_instret",      instret, 64'd101);
      check("halt_pc_hold",      commit_pc, 64'h8000_0010);
      check("halt_x5",           gpr(5), exp_rf[5]);
      check("halt_is_break",     64'(is_break), 64'd1);

      // Asynchronous reset while halted
      #2;
      rst = 1'b1;
      #1;
      check("arst_is_break",     64'(is_break), 64'd0);
      check("arst_commit_valid", 64'(commit_valid), 64'd0);
      check("arst_commit_pc",    commit_pc, 64'd0);
      check("arst_instret",      instret, 64'd0);
      check("arst_in_ready",     64'(bus.in_ready), 64'd1);
      check("arst_rf_any",       64'(|rf_flat), 64'd0);
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b0;

      // Watchdog: 7 idle edges quiet, 8th fires, then sticky
      repeat (7) step();
      check("wd_before", 64'(timeout), 64'd0);
      step();
      check("wd_fired", 64'(timeout), 64'd1);
      drive(1'b1, 64'h8000_0020, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      check("wd_sticky", 64'(timeout), 64'd1);

      // Watchdog: fire in the 8th cycle wins and clears the count
      do_reset();
      repeat (7) step();
      drive(1'b1, 64'h8000_0030, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      check("wd_fire_wins", 64'(timeout), 64'd0);
      repeat (6) step();
      check("wd_cleared", 64'(timeout), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
